// File: rtl/lcd8080_bus_receiver.sv
// Panel-side receiver for the 8-bit 8080-style LCD write bus.
// It decodes commands, tracks the CASET/PASET window and emits one pulse for each completed RAMWR pixel.
module lcd8080_bus_receiver #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int BPP     = 2,
  parameter int COORD_W = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           data_i,
  input  logic                 csx_i,
  input  logic                 resx_i,
  input  logic                 dcx_i,
  input  logic                 wrx_i,
  input  logic                 rdx_i,
  output logic                 cmd_valid_o,
  output logic [7:0]           cmd_code_o,
  output logic                 pix_valid_o,
  output logic [COORD_W-1:0]   pix_x_o,
  output logic [COORD_W-1:0]   pix_y_o,
  output logic [8*BPP-1:0]     pix_data_o,
  output logic                 protocol_err_o
);

  localparam int PW = 8 * BPP;

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_IGNORE} state_e;

  typedef struct packed {
    logic       wr;
    logic       cs_rise;
    logic       err;
    logic       dc;
    logic [7:0] data;
  } bus_ev_t;

  // Two-flop synchronisers. Strobes reset to their idle-high level so that releasing reset creates no false edge.
  logic [1:0] csx_sq, dcx_sq, wrx_sq, rdx_sq, resx_sq;
  logic [7:0] data_s0_q, data_s1_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csx_sq    <= 2'b11;
      wrx_sq    <= 2'b11;
      rdx_sq    <= 2'b11;
      dcx_sq    <= 2'b00;
      resx_sq   <= 2'b00;
      data_s0_q <= '0;
      data_s1_q <= '0;
    end else begin
      csx_sq    <= {csx_sq[0], csx_i};
      wrx_sq    <= {wrx_sq[0], wrx_i};
      rdx_sq    <= {rdx_sq[0], rdx_i};
      dcx_sq    <= {dcx_sq[0], dcx_i};
      resx_sq   <= {resx_sq[0], resx_i};
      data_s0_q <= data_i;
      data_s1_q <= data_s0_q;
    end
  end

  logic csx_s, wrx_s, rdx_s, dcx_s, soft_rst;
  assign csx_s    = csx_sq[1];
  assign wrx_s    = wrx_sq[1];
  assign rdx_s    = rdx_sq[1];
  assign dcx_s    = dcx_sq[1];
  assign soft_rst = ~resx_sq[1];

  logic    wrx_prev_q, csx_prev_q, viol_prev_q, bad_q;
  logic    viol, wr_rise;
  bus_ev_t ev_in, ev1_q, ev2_q;

  assign viol    = ~csx_s & ~wrx_s & ~rdx_s;
  assign wr_rise = ~csx_s & wrx_s & ~wrx_prev_q;

  always_comb begin
    ev_in.wr      = wr_rise & ~bad_q;
    ev_in.cs_rise = csx_s & ~csx_prev_q;
    ev_in.err     = viol & ~viol_prev_q;
    ev_in.dc      = dcx_s;
    ev_in.data    = data_s1_q;
  end

  // Edge history keeps running while resx is low, so a write already in progress is not seen as new when resx releases.
  // The two-stage event delay aligns every pulse to four edges after the pin sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrx_prev_q  <= 1'b1;
      csx_prev_q  <= 1'b1;
      viol_prev_q <= 1'b0;
      bad_q       <= 1'b0;
      ev1_q       <= '0;
      ev2_q       <= '0;
    end else begin
      wrx_prev_q  <= wrx_s;
      csx_prev_q  <= csx_s;
      viol_prev_q <= viol;
      if (soft_rst) begin
        bad_q <= 1'b0;
        ev1_q <= '0;
        ev2_q <= '0;
      end else begin
        if (ev_in.err)                   bad_q <= 1'b1;
        else if (wr_rise || ev_in.cs_rise) bad_q <= 1'b0;
        ev1_q <= ev_in;
        ev2_q <= ev1_q;
      end
    end
  end

  state_e             state_q, state_d;
  logic [COORD_W-1:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [1:0]         bcnt_q, bcnt_d, pidx_q, pidx_d;
  logic [23:0]        par_q, par_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic               cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d, err_q, err_d;
  logic [7:0]         cmd_code_q, cmd_code_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [PW-1:0]      pix_data_q, pix_data_d;

  logic [COORD_W-1:0] start_v, end_v;
  logic [PW-1:0]      acc_next;
  logic               win_ok;

  assign start_v  = COORD_W'(par_q[23:8]);
  assign end_v    = COORD_W'({par_q[7:0], ev2_q.data});
  assign acc_next = PW'({acc_q, ev2_q.data});
  assign win_ok   = (start_v <= end_v) &&
                    (int'(end_v) < ((state_q == S_CASET) ? WIDTH : HEIGHT));

  // NOTE: every _d gets a default before any branch; otherwise always_comb infers latches.
  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    ec_d        = ec_q;
    sp_d        = sp_q;
    ep_d        = ep_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    bcnt_d      = bcnt_q;
    pidx_d      = pidx_q;
    par_d       = par_q;
    acc_d       = acc_q;
    cmd_code_d  = cmd_code_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_data_d  = pix_data_q;
    cmd_valid_d = 1'b0;
    pix_valid_d = 1'b0;
    err_d       = ev2_q.err;

    if (soft_rst) begin
      state_d    = S_IDLE;
      sc_d       = '0;
      ec_d       = COORD_W'(WIDTH - 1);
      sp_d       = '0;
      ep_d       = COORD_W'(HEIGHT - 1);
      cx_d       = '0;
      cy_d       = '0;
      bcnt_d     = '0;
      pidx_d     = '0;
      par_d      = '0;
      acc_d      = '0;
      cmd_code_d = '0;
      pix_x_d    = '0;
      pix_y_d    = '0;
      pix_data_d = '0;
      err_d      = 1'b0;
    end else if (ev2_q.cs_rise) begin
      bcnt_d = '0;
    end else if (ev2_q.wr && !ev2_q.dc) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = ev2_q.data;
      pidx_d      = '0;
      bcnt_d      = '0;
      case (ev2_q.data)
        8'h2A:   state_d = S_CASET;
        8'h2B:   state_d = S_PASET;
        8'h2C: begin
          state_d = S_RAMWR;
          cx_d    = sc_q;
          cy_d    = sp_q;
        end
        8'h3C:   state_d = S_RAMWR;
        default: state_d = S_IGNORE;
      endcase
    end else if (ev2_q.wr) begin
      case (state_q)
        S_CASET, S_PASET: begin
          par_d  = {par_q[15:0], ev2_q.data};
          pidx_d = pidx_q + 2'd1;
          if (pidx_q == 2'd3) begin
            state_d = S_IGNORE;
            if (!win_ok) begin
              err_d = 1'b1;
            end else if (state_q == S_CASET) begin
              sc_d = start_v;
              ec_d = end_v;
            end else begin
              sp_d = start_v;
              ep_d = end_v;
            end
          end
        end
        S_RAMWR: begin
          acc_d = acc_next;
          if (bcnt_q == 2'(BPP - 1)) begin
            bcnt_d      = '0;
            pix_valid_d = 1'b1;
            pix_x_d     = cx_q;
            pix_y_d     = cy_q;
            pix_data_d  = acc_next;
            if (cx_q < ec_q) begin
              cx_d = cx_q + COORD_W'(1);
            end else begin
              cx_d = sc_q;
              cy_d = (cy_q < ep_q) ? cy_q + COORD_W'(1) : sp_q;
            end
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      sc_q        <= '0;
      ec_q        <= COORD_W'(WIDTH - 1);
      sp_q        <= '0;
      ep_q        <= COORD_W'(HEIGHT - 1);
      cx_q        <= '0;
      cy_q        <= '0;
      bcnt_q      <= '0;
      pidx_q      <= '0;
      par_q       <= '0;
      acc_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      ec_q        <= ec_d;
      sp_q        <= sp_d;
      ep_q        <= ep_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      bcnt_q      <= bcnt_d;
      pidx_q      <= pidx_d;
      par_q       <= par_d;
      acc_q       <= acc_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
      err_q       <= err_d;
    end
  end

  assign cmd_valid_o    = cmd_valid_q;
  assign cmd_code_o     = cmd_code_q;
  assign pix_valid_o    = pix_valid_q;
  assign pix_x_o        = pix_x_q;
  assign pix_y_o        = pix_y_q;
  assign pix_data_o     = pix_data_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_lcd8080_bus_receiver.sv
// Self-checking bench for lcd8080_bus_receiver.
// A queue-based panel model predicts every pulse, and directed scenarios pin that model with literal values.
module tb_lcd8080_bus_receiver;

  localparam int WIDTH   = 240;
  localparam int HEIGHT  = 320;
  localparam int BPP     = 2;
  localparam int COORD_W = 9;
  localparam int CMAX    = 1 << COORD_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [7:0]         data;
  logic               csx, resx, dcx, wrx, rdx;
  logic               cmd_valid_o, pix_valid_o, protocol_err_o;
  logic [7:0]         cmd_code_o;
  logic [COORD_W-1:0] pix_x_o, pix_y_o;
  logic [8*BPP-1:0]   pix_data_o;

  always #5 clk = ~clk;

  lcd8080_bus_receiver #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPP(BPP), .COORD_W(COORD_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .csx_i(csx), .resx_i(resx),
    .dcx_i(dcx), .wrx_i(wrx), .rdx_i(rdx),
    .cmd_valid_o(cmd_valid_o), .cmd_code_o(cmd_code_o),
    .pix_valid_o(pix_valid_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
    .pix_data_o(pix_data_o), .protocol_err_o(protocol_err_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Panel model: kind 1 = command, 2 = pixel, 3 = protocol error.
  typedef struct {int kind; int a; int b; int c;} exp_t;
  exp_t exp_q[$];
  int   m_mode;  // 0 idle/ignore, 1 column window, 2 page window, 3 pixel write
  int   m_sc, m_ec, m_sp, m_ep, m_x, m_y;
  int   m_par[$];
  int   m_pix[$];

  function automatic void m_reset();
    m_mode = 0;
    m_sc = 0; m_ec = WIDTH - 1; m_sp = 0; m_ep = HEIGHT - 1;
    m_x = 0; m_y = 0;
    m_par.delete(); m_pix.delete(); exp_q.delete();
  endfunction

  function automatic void m_cmd(int c);
    exp_q.push_back('{1, c, 0, 0});
    m_par.delete(); m_pix.delete();
    case (c)
      'h2A: m_mode = 1;
      'h2B: m_mode = 2;
      'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; end
      'h3C: m_mode = 3;
      default: m_mode = 0;
    endcase
  endfunction

  function automatic void m_data(int d);
    int s, e, lim, v;
    if (m_mode == 1 || m_mode == 2) begin
      m_par.push_back(d);
      if (m_par.size() == 4) begin
        s   = (m_par[0] * 256 + m_par[1]) % CMAX;
        e   = (m_par[2] * 256 + m_par[3]) % CMAX;
        lim = (m_mode == 1) ? WIDTH : HEIGHT;
        if (s <= e && e < lim) begin
          if (m_mode == 1) begin m_sc = s; m_ec = e; end
          else             begin m_sp = s; m_ep = e; end
        end else begin
          exp_q.push_back('{3, 0, 0, 0});
        end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      m_pix.push_back(d);
      if (m_pix.size() == BPP) begin
        v = 0;
        foreach (m_pix[i]) v = v * 256 + m_pix[i];
        exp_q.push_back('{2, m_x, m_y, v});
        m_pix.delete();
        if (m_x < m_ec) m_x++;
        else begin
          m_x = m_sc;
          m_y = (m_y < m_ep) ? m_y + 1 : m_sp;
        end
      end
    end
  endfunction

  // Compare process and pulse logs used by the literal checks.
  bit chk_en = 1'b0;
  int pulse_cnt = 0;
  int last_code, last_x, last_y, last_d;
  int px[$], py[$], pd[$], cl[$];
  int err_seen;

  task automatic clr_logs();
    px.delete(); py.delete(); pd.delete(); cl.delete(); err_seen = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cmd_valid_o || pix_valid_o || protocol_err_o) pulse_cnt++;
    if (chk_en) begin
      if (cmd_valid_o && pix_valid_o) check("cmd_pix_overlap", 1, 0);
      if (cmd_valid_o) begin
        cl.push_back(int'(cmd_code_o));
        if (exp_q.size() == 0) check("cmd_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("cmd_kind", 1, e.kind);
          check("cmd_code", cmd_code_o, e.a);
          last_code = e.a;
        end
      end
      if (pix_valid_o) begin
        px.push_back(int'(pix_x_o)); py.push_back(int'(pix_y_o)); pd.push_back(int'(pix_data_o));
        if (exp_q.size() == 0) check("pix_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pix_kind", 2, e.kind);
          check("pix_x", pix_x_o, e.a);
          check("pix_y", pix_y_o, e.b);
          check("pix_data", pix_data_o, e.c);
          last_x = e.a; last_y = e.b; last_d = e.c;
        end
      end
      if (protocol_err_o) begin
        err_seen++;
        if (exp_q.size() == 0) check("err_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("err_kind", 3, e.kind);
        end
      end
      check("cmd_code_hold", cmd_code_o, last_code);
      check("pix_x_hold", pix_x_o, last_x);
      check("pix_y_hold", pix_y_o, last_y);
      check("pix_data_hold", pix_data_o, last_d);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(bit dc, int d);
    dcx = dc; data = d[7:0]; wrx = 1'b0;
    tick(4);
    wrx = 1'b1;
    if (dc) m_data(d); else m_cmd(d);
    tick(4);
  endtask

  task automatic send_bad(int d);
    dcx = 1'b1; data = d[7:0]; wrx = 1'b0;
    tick(2);
    rdx = 1'b0;
    exp_q.push_back('{3, 0, 0, 0});
    tick(3);
    rdx = 1'b1;
    tick(2);
    wrx = 1'b1;
    tick(4);
  endtask

  task automatic csx_pulse();
    csx = 1'b1;
    m_pix.delete();
    tick(4);
    csx = 1'b0;
    tick(4);
  endtask

  task automatic send_window(int c, int lim);
    int s, e;
    send(0, c);
    if ($urandom_range(0, 3) == 0) begin
      s = $urandom_range(0, 65535); e = $urandom_range(0, 65535);
    end else begin
      s = $urandom_range(0, lim - 1); e = $urandom_range(s, lim);
    end
    send(1, s >> 8); send(1, s & 255); send(1, e >> 8); send(1, e & 255);
  endtask

  task automatic model_cleared();
    m_reset();
    last_code = 0; last_x = 0; last_y = 0; last_d = 0;
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_cmd_valid"}, cmd_valid_o, 0);
    check({tag, "_cmd_code"}, cmd_code_o, 0);
    check({tag, "_pix_valid"}, pix_valid_o, 0);
    check({tag, "_pix_xy"}, {pix_x_o, pix_y_o}, 0);
    check({tag, "_pix_data"}, pix_data_o, 0);
    check({tag, "_err"}, protocol_err_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; resx = 1'b0; csx = 1'b1; wrx = 1'b1; rdx = 1'b1; dcx = 1'b0; data = '0;
    model_cleared();
    tick(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick(3);
    // A write while resx is low must produce nothing.
    csx = 1'b0;
    dcx = 1'b0; data = 8'h2C; wrx = 1'b0; tick(4); wrx = 1'b1; tick(10);
    check("resx_low_no_pulse", pulse_cnt, 0);
    check_outputs_zero("resx_low");
    resx = 1'b1;
    tick(5);
    chk_en = 1'b1;

    // RAMWR from reset state.
    clr_logs();
    send(0, 'h2C);
    send(1, 'hAB); send(1, 'hCD); send(1, 'h12); send(1, 'h34);
    tick(10);
    check("t1_cmd_count", cl.size(), 1);
    check("t1_cmd_code", cl[0], 'h2C);
    check("t1_pix_count", px.size(), 2);
    check("t1_pix0", {px[0][15:0], py[0][15:0]}, 32'h0000_0000);
    check("t1_pix0_data", pd[0], 'hABCD);
    check("t1_pix1", {px[1][15:0], py[1][15:0]}, 32'h0001_0000);
    check("t1_pix1_data", pd[1], 'h1234);

    // Small window with wrap.
    clr_logs();
    send(0, 'h2A); send(1, 0); send(1, 5); send(1, 0); send(1, 6);
    send(0, 'h2B); send(1, 0); send(1, 2); send(1, 0); send(1, 3);
    send(0, 'h2C);
    for (int i = 0; i < 10; i++) send(1, $urandom_range(0, 255));
    tick(10);
    check("t2_pix_count", px.size(), 5);
    begin
      int ex[5] = '{5, 6, 5, 6, 5};
      int ey[5] = '{2, 2, 3, 3, 2};
      for (int i = 0; i < 5; i++) begin
        check("t2_pix_x", px[i], ex[i]);
        check("t2_pix_y", py[i], ey[i]);
      end
    end

    // resx pulse restores the default window; an invalid CASET is rejected.
    chk_en = 1'b0;
    resx = 1'b0;
    tick(6);
    model_cleared();
    check_outputs_zero("resx_pulse");
    resx = 1'b1;
    tick(4);
    chk_en = 1'b1;
    clr_logs();
    send(0, 'h2A); send(1, 0); send(1, 9); send(1, 0); send(1, 4);
    send(0, 'h2C);
    send(1, 'h01); send(1, 'h02); send(1, 'h03); send(1, 'h04);
    tick(10);
    check("t3_err_count", err_seen, 1);
    check("t3_pix0", {px[0][15:0], py[0][15:0]}, 32'h0000_0000);
    check("t3_pix1", {px[1][15:0], py[1][15:0]}, 32'h0001_0000);

    // Partial pixel discarded by a csx rising edge.
    clr_logs();
    send(0, 'h2C);
    send(1, 'h55);
    csx_pulse();
    send(1, 'h11); send(1, 'h22);
    tick(10);
    check("t4_pix_count", px.size(), 1);
    check("t4_pix0", {px[0][15:0], py[0][15:0]}, 32'h0000_0000);
    check("t4_pix0_data", pd[0], 'h1122);

    // Exact pulse latency, then a read/write collision.
    clr_logs();
    send(0, 'h2C);
    send(1, 'hA5);
    dcx = 1'b1; data = 8'h5A; wrx = 1'b0;
    tick(4);
    wrx = 1'b1;
    m_data('h5A);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check("latency_pix_valid", pix_valid_o, (k == 5));
    end
    #1;
    tick(4);
    send_bad('h77);
    tick(10);
    check("t5_err_count", err_seen, 1);
    check("t5_pix_count", px.size(), 1);

    // Continue (0x3C) versus fresh start (0x2C).
    clr_logs();
    send(0, 'h2C);
    for (int i = 0; i < 8; i++) send(1, i);
    send(0, 'h3C);
    send(1, 'hC0); send(1, 'hDE);
    send(0, 'h2C);
    send(1, 'hBE); send(1, 'hEF);
    tick(10);
    check("t6_pix_count", px.size(), 6);
    check("t6_pix3", {px[3][15:0], py[3][15:0]}, 32'h0003_0000);
    check("t6_pix4", {px[4][15:0], py[4][15:0]}, 32'h0004_0000);
    check("t6_pix4_data", pd[4], 'hC0DE);
    check("t6_pix5", {px[5][15:0], py[5][15:0]}, 32'h0000_0000);

    // Asynchronous reset in the middle of a pixel.
    clr_logs();
    send(0, 'h2C);
    send(1, 'h77);
    tick(6);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    tick(2);
    rst_n = 1'b1;
    model_cleared();
    tick(6);
    chk_en = 1'b1;
    send(1, 'h88);
    send(0, 'h2C);
    send(1, 'h99); send(1, 'hAA);
    tick(10);
    check("t7_pix_count", px.size(), 1);
    check("t7_pix0", {px[0][15:0], py[0][15:0]}, 32'h0000_0000);
    check("t7_pix0_data", pd[0], 'h99AA);

    // Randomised traffic checked against the model.
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       send_window('h2A, WIDTH);
      else if (r < 16) send_window('h2B, HEIGHT);
      else if (r < 24) send(0, 'h2C);
      else if (r < 28) send(0, 'h3C);
      else if (r < 31) send(0, $urandom_range(0, 255));
      else if (r < 35) csx_pulse();
      else if (r < 38) send_bad($urandom_range(0, 255));
      else             send(1, $urandom_range(0, 255));
    end
    tick(20);
    check("expect_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
